spi_config_master: RTL and testbench

SPI_CONFIG_MASTER -- requirements
Module: spi_config_master

---
 rtl/spi_config_pkg.sv | 36 +++
 rtl/spi_config_master_tick.sv | 46 ++++
 rtl/spi_config_master.sv | 210 +++++++++++++++++++++
 tb/tb_spi_config_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_config_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_config_pkg
//  Description : Shared constants for the SPI configuration master: config
//                vector width, field bit positions inside the config vector,
//                and the transaction state encoding.
//  Options     : none (readback is selected by SPI_CFG_READBACK_EN in the top)
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_config_pkg;

    // Width of the configuration vector shifted to the slave
    localparam int DW = 36;

    // Field positions (LSB of each field) inside the config vector
    localparam int ACC_INC_POS        = 0;   // 24-bit accumulator increment
    localparam int DF_INC_COEF_POS    = 24;  // 2-bit decimation coefficient step
    localparam int DF_INC_FACT_POS    = 26;  // 2-bit decimation factor step
    localparam int DAC_ENA_POS        = 28;  // DAC enable
    localparam int DITH_FACT_POS      = 29;  // 2-bit dither factor
    localparam int USB_I2SN_POS       = 31;  // 1 = USB audio source, 0 = I2S
    localparam int AUDIO_CHAN_SEL_POS = 32;  // 2-bit audio channel select
    localparam int I2S_WS_ALIGN_POS   = 34;  // I2S word-select alignment
    localparam int SPI_OVERRIDE_POS   = 35;  // SPI register override (MSB)

    // Transaction state encoding
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        END  = 3'd4
    } spi_state_e;

endpackage : spi_config_pkg
`default_nettype wire

// File: rtl/spi_config_master_tick.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tick_gen
//  Description : Phase timer for the SPI master. While run is high it emits
//                a one-cycle tick every CLK_DIV clk cycles; the first tick
//                comes CLK_DIV cycles after run rises. Dropping run restarts
//                the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] c_term_cnt = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = run && (cnt_q == c_term_cnt);

    // Count up while running, wrap on each tick so every phase starts at 0
    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Tick counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : spi_tick_gen
`default_nettype wire

// File: rtl/spi_config_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_config_master
//  Description : Mode-0 SPI master that writes one DW-bit configuration
//                vector per start request, MSB first, and (optionally) reads
//                the previous slave contents back on spi_miso.
//                Chip-select stays low for CLK_DIV*(2*DW+1) cycles: one lead
//                phase followed by DW high/low clock phase pairs.
//  Options     : SPI_CFG_READBACK_EN - when defined, spi_miso is sampled in
//                the last HIGH cycle of each bit and the assembled word is
//                published on rx_data in the END cycle. When undefined,
//                rx_data is tied to zero and spi_miso is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_config_master
    import spi_config_pkg::*;
#(
    parameter int DW      = spi_config_pkg::DW,
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] tx_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rx_data,
    output logic          spi_clk,
    output logic          spi_csn,
    output logic          spi_mosi,
    input  logic          spi_miso
);

    localparam int             BCW        = $clog2(DW + 1);
    localparam logic [BCW-1:0] c_last_bit = BCW'(DW);

    spi_state_e     state_q;
    spi_state_e     state_d;
    logic [DW-1:0]  tx_sh_q;
    logic [DW-1:0]  tx_sh_d;
    logic [BCW-1:0] bit_cnt_q;
    logic [BCW-1:0] bit_cnt_d;
    logic           busy_q;
    logic           busy_d;
    logic           done_q;
    logic           done_d;
    logic           sclk_q;
    logic           sclk_d;
    logic           csn_q;
    logic           csn_d;
    logic           mosi_q;
    logic           mosi_d;

    logic           w_run;
    logic           w_tick;

    // Phase timer runs only in the timed states; IDLE and END hold it at zero
    assign w_run = (state_q == LEAD) || (state_q == HIGH) || (state_q == LOW);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .tick (w_tick)
    );

    // Next-state and registered-output logic; outputs are computed for the
    // state being entered so every pin comes straight from a flop
    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        csn_d     = csn_q;
        mosi_d    = mosi_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LEAD;
                    tx_sh_d   = tx_data;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    csn_d     = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = tx_data[DW-1];
                end
            end
            LEAD: begin
                if (w_tick) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                end
            end
            HIGH: begin
                // Falling edge: present the next bit and count the one just sent
                if (w_tick) begin
                    state_d   = LOW;
                    sclk_d    = 1'b0;
                    tx_sh_d   = {tx_sh_q[DW-2:0], 1'b0};
                    mosi_d    = tx_sh_q[DW-2];
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            LOW: begin
                if (w_tick) begin
                    if (bit_cnt_q == c_last_bit) begin
                        state_d = END;
                        csn_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        mosi_d  = 1'b0;
                    end else begin
                        state_d = HIGH;
                        sclk_d  = 1'b1;
                    end
                end
            end
            END: begin
                // One-cycle gap: a start seen here is only taken in IDLE
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                csn_d   = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_sh_q   <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            csn_q     <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            csn_q     <= csn_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_clk  = sclk_q;
    assign spi_csn  = csn_q;
    assign spi_mosi = mosi_q;

`ifdef SPI_CFG_READBACK_EN
    logic          w_sample;
    logic          w_finish;
    logic [DW-1:0] rx_sh_q;
    logic [DW-1:0] rx_sh_d;
    logic [DW-1:0] rx_data_q;
    logic [DW-1:0] rx_data_d;

    // Sample in the last HIGH cycle; publish when entering END
    assign w_sample = (state_q == HIGH) && w_tick;
    assign w_finish = (state_q == LOW) && w_tick && (bit_cnt_q == c_last_bit);

    // Readback shifter (LSB-in) and result holding register
    always_comb begin
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        if (w_sample) begin
            rx_sh_d = {rx_sh_q[DW-2:0], spi_miso};
        end
        if (w_finish) begin
            rx_data_d = rx_sh_q;
        end
    end

    // Readback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sh_q   <= '0;
            rx_data_q <= '0;
        end else begin
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`else
    logic w_unused_miso;

    assign w_unused_miso = spi_miso;
    assign rx_data       = '0;
`endif

endmodule : spi_config_master
`default_nettype wire

// File: tb/tb_spi_config_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_config_master
//  Description : Self-checking bench for spi_config_master. A table of write
//                transactions runs against a behavioural config slave,
//                followed by hand-written sequences for start-in-END,
//                reset priority, mid-transfer abort and CLK_DIV=1 timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_config_master;
    import spi_config_pkg::*;

    localparam int W = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter DUT
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         busy, done, spi_clk, spi_csn, spi_mosi, spi_miso;
    logic [W-1:0] rx_data;

    // CLK_DIV = 1 DUT
    logic         start1 = 1'b0;
    logic [W-1:0] tx_data1 = '0;
    logic         busy1, done1, spi_clk1, spi_csn1, spi_mosi1;
    logic         spi_miso1 = 1'b0;
    logic [W-1:0] rx_data1;

    spi_config_master #(.DW(W), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    spi_config_master #(.DW(W), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(tx_data1),
        .busy(busy1), .done(done1), .rx_data(rx_data1),
        .spi_clk(spi_clk1), .spi_csn(spi_csn1), .spi_mosi(spi_mosi1),
        .spi_miso(spi_miso1)
    );

    // Config slave: reloads its shifter from the stored vector when selected,
    // captures mosi on sclk rise, shifts on sclk fall, and commits only a
    // complete DW-bit frame when deselected.
    logic [W-1:0] slv_vec = 36'h05F3D0000;
    logic [W-1:0] slv_sr  = 36'h05F3D0000;
    int           slv_bits = 0;
    logic         slv_cap = 1'b0;
    logic         slv_prev_clk = 1'b0;
    logic         slv_prev_csn = 1'b1;

    assign spi_miso = slv_sr[W-1];

    always begin
        @(posedge clk); #1;
        if (slv_prev_csn && !spi_csn) begin
            slv_sr   = slv_vec;
            slv_bits = 0;
        end else if (!slv_prev_csn && spi_csn) begin
            if (slv_bits == W) slv_vec = slv_sr;
        end else if (!spi_csn) begin
            if (spi_clk && !slv_prev_clk) slv_cap = spi_mosi;
            if (!spi_clk && slv_prev_clk) begin
                slv_sr   = {slv_sr[W-2:0], slv_cap};
                slv_bits = slv_bits + 1;
            end
        end
        slv_prev_clk = spi_clk;
        slv_prev_csn = spi_csn;
    end

    // Line monitors, sampled 1 time unit after each rising clk edge
    int csn_low_cnt = 0, rise_cnt = 0, done_cnt = 0, csn_fall_cnt = 0;
    int mosi_err = 0, rx_hold_err = 0;
    int csn1_low_cnt = 0, rise1_cnt = 0, done1_cnt = 0, mosi1_err = 0;

    always begin : mon0
        logic         p_sclk, p_mosi, p_csn;
        logic [W-1:0] p_rx;
        p_sclk = 1'b0; p_mosi = 1'b0; p_csn = 1'b1; p_rx = '0;
        forever begin
            @(posedge clk); #1;
            if (!spi_csn) csn_low_cnt++;
            if (!spi_csn && p_csn) csn_fall_cnt++;
            if (spi_clk && !p_sclk) begin
                rise_cnt++;
                if (spi_mosi !== p_mosi) mosi_err++;
            end
            if (done) done_cnt++;
            if (!rst && !done && (rx_data !== p_rx)) rx_hold_err++;
            p_sclk = spi_clk; p_mosi = spi_mosi; p_csn = spi_csn; p_rx = rx_data;
        end
    end

    always begin : mon1
        logic p_sclk, p_mosi;
        p_sclk = 1'b0; p_mosi = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!spi_csn1) csn1_low_cnt++;
            if (spi_clk1 && !p_sclk) begin
                rise1_cnt++;
                if (spi_mosi1 !== p_mosi) mosi1_err++;
            end
            if (done1) done1_cnt++;
            p_sclk = spi_clk1; p_mosi = spi_mosi1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_rx(input logic [W-1:0] v);
`ifdef SPI_CFG_READBACK_EN
        return v;
`else
        return '0 & v;
`endif
    endfunction

    // Caller is at a negedge; drives start for this cycle and waits for done.
    // lat = cycles from the start cycle through the done cycle inclusive.
    task automatic drive_txn(input logic [W-1:0] tx, input bit pulse, output int lat);
        int n;
        start = 1'b1; tx_data = tx; lat = -1; n = 1;
        while (n < 1000) begin
            @(negedge clk); n++;
            start   = pulse && (n == 6 || n == 41);
            tx_data = start ? ~tx : {tx[W-2:0], tx[W-1]};
            if (done) begin lat = n; break; end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] tx;
        bit           pulse;
        logic [W-1:0] rx_exp;
        logic [W-1:0] vec_exp;
    } txn_vec_t;

    txn_vec_t tbl[6];

    initial begin
        int lat;
        int n;

        tbl[0] = '{36'h800000001, 1'b0, 36'h05F3D0000, 36'h800000001};
        tbl[1] = '{36'h123456789, 1'b0, 36'h800000001, 36'h123456789};
        tbl[2] = '{36'h0AAAA5555, 1'b0, 36'h123456789, 36'h0AAAA5555};
        tbl[3] = '{36'hFFFFFFFFF, 1'b0, 36'h0AAAA5555, 36'hFFFFFFFFF};
        tbl[4] = '{36'h000000000, 1'b0, 36'hFFFFFFFFF, 36'h000000000};
        tbl[5] = '{36'h0F0F0F0F0, 1'b1, 36'h000000000, 36'h0F0F0F0F0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_csn",  spi_csn,  1);
        check("reset_sclk", spi_clk,  0);
        check("reset_mosi", spi_mosi, 0);
        check("reset_busy", busy,     0);
        check("reset_done", done,     0);
        check("reset_rx",   rx_data,  0);

        // Reset wins over a simultaneous start
        rst = 1'b1; start = 1'b1; tx_data = 36'h123123123;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", busy, 0);
        check("rst_prio_csn",  spi_csn, 1);
        @(negedge clk);
        check("rst_prio_busy_later", busy, 0);

        // Table-driven transactions
        for (int i = 0; i < 6; i++) begin
            csn_low_cnt = 0; rise_cnt = 0; done_cnt = 0; csn_fall_cnt = 0; mosi_err = 0;
            @(negedge clk);
            drive_txn(tbl[i].tx, tbl[i].pulse, lat);
            repeat (2) @(negedge clk);
            check($sformatf("t%0d_latency", i),  lat, 148);
            check($sformatf("t%0d_csn_low", i),  csn_low_cnt, 146);
            check($sformatf("t%0d_rises", i),    rise_cnt, 36);
            check($sformatf("t%0d_csn_fall", i), csn_fall_cnt, 1);
            check($sformatf("t%0d_done_cnt", i), done_cnt, 1);
            check($sformatf("t%0d_mosi_stab", i), mosi_err, 0);
            check($sformatf("t%0d_rx", i),       rx_data, exp_rx(tbl[i].rx_exp));
            check($sformatf("t%0d_slave", i),    slv_vec, tbl[i].vec_exp);
        end

        // Start raised in the END cycle is taken only in the following IDLE cycle
        @(negedge clk);
        drive_txn(36'h3C3C3C3C3, 1'b0, lat);
        check("endA_latency", lat, 148);
        start = 1'b1; tx_data = 36'hC3C3C3C3C;
        @(negedge clk);
        check("end_start_busy_idle", busy, 0);
        check("end_start_csn_idle",  spi_csn, 1);
        drive_txn(36'hC3C3C3C3C, 1'b0, lat);
        repeat (2) @(negedge clk);
        check("endB_latency", lat, 148);
        check("endB_rx",      rx_data, exp_rx(36'h3C3C3C3C3));
        check("endB_slave",   slv_vec, 36'hC3C3C3C3C);

        // Reset during bit 17 aborts without done and clears rx_data
        @(negedge clk);
        done_cnt = 0; rise_cnt = 0;
        start = 1'b1; tx_data = 36'h5A5A5A5A5;
        @(negedge clk);
        start = 1'b0; n = 0;
        while (rise_cnt < 17 && n < 1000) begin @(negedge clk); n++; end
        check("abort_at_bit17", rise_cnt, 17);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_csn",  spi_csn,  1);
        check("abort_sclk", spi_clk,  0);
        check("abort_mosi", spi_mosi, 0);
        check("abort_busy", busy,     0);
        check("abort_rx",   rx_data,  0);
        repeat (200) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_slave",   slv_vec, 36'hC3C3C3C3C);

        @(negedge clk);
        drive_txn(36'h000000001, 1'b0, lat);
        repeat (2) @(negedge clk);
        check("recover_latency", lat, 148);
        check("recover_rx",      rx_data, exp_rx(36'hC3C3C3C3C));
        check("recover_slave",   slv_vec, 36'h000000001);
        check("rx_hold", rx_hold_err, 0);

        // CLK_DIV = 1 instance: 73-cycle select window
        csn1_low_cnt = 0; rise1_cnt = 0; done1_cnt = 0; mosi1_err = 0;
        @(negedge clk);
        start1 = 1'b1; tx_data1 = 36'hFFFFFFFFF; n = 1; lat = -1;
        while (n < 1000) begin
            @(negedge clk); n++;
            start1 = 1'b0;
            if (done1) begin lat = n; break; end
        end
        repeat (2) @(negedge clk);
        check("div1_latency",   lat, 75);
        check("div1_csn_low",   csn1_low_cnt, 73);
        check("div1_rises",     rise1_cnt, 36);
        check("div1_mosi_stab", mosi1_err, 0);
        check("div1_done_cnt",  done1_cnt, 1);
        check("div1_rx",        rx_data1, exp_rx(36'h000000000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spi_config_master
`default_nettype wire
